timer_compare: RTL and testbench
================================

// Module: timer_compare
// PURPOSE
//  Writable memory-mapped machine timer: 64-bit free-running tick counter plus
//  64-bit compare register, raising a level interrupt when count >= compare.
//  Bus-write side of the timer: CPU programs count/compare/control, reads back.
//  Sits on the MMIO data bus beside the read-only uptime timer; irq feeds the core's MTIP.
// PARAMETERS
//  PRESCALE   100  clock cycles per count tick (>=1; 100 @100MHz = 1us tick)
//  PS_W       7    prescaler counter width, must hold PRESCALE-1
// PORTS
//  clock  in   1   system clock, sole clock domain
//  reset  in   1   asynchronous, active-high reset
//  sel    in   1   peripheral select, one-cycle access strobe
//  we     in   1   1=write, 0=read (qualified by sel)
//  addr   in   32  byte address; addr[4:2] selects register
//  din    in   32  write data
//  dout   out  32  read data, registered
//  irq    out  1   timer interrupt, registered level
// BEHAVIOUR
//  Register map (addr[4:2]): 0 CNT_LO, 1 CNT_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL,
//   5 PER_LO, 6 PER_HI, 7 reserved (reads 0, writes ignored).
//  CTRL: b0 EN (count), b1 IE (irq enable), b2 PEND (read; write 1 clears),
//   b3 PERIODIC; b31:4 read 0.
//  Reset: cnt=0, cmp=64'hFFFF_FFFF_FFFF_FFFF, per=0, CTRL=0, prescaler=0,
//   shadows=0, hi-latch=0, dout=0, irq=0.
//  Prescaler: counts 0..PRESCALE-1 while EN; tick on PRESCALE-1, wraps to 0;
//   cleared when EN=0. On tick cnt<=cnt+1, 64-bit wrap FFFF..FF->0.
//  64-bit writes: LO write loads 32-bit shadow only; HI write commits
//   {din,shadow} in same cycle. HI write without prior LO uses last shadow.
//  CNT commit overrides a same-cycle tick; prescaler reset to 0 on CNT commit.
//  64-bit reads: CNT_LO/CMP_LO read latches the matching upper word into a
//   hi-latch; following HI read returns latch (tear-free). HI read with no
//   prior LO read returns latch contents.
//  Read latency: dout updated the cycle after sel&!we; held when sel=0.
//   Writes do not change dout.
//  Match: match = EN & (cnt >= cmp), unsigned, evaluated on registered values.
//   match sets PEND next cycle. PEND cleared by CTRL write with din[2]=1;
//   set beats clear in the same cycle (PEND stays 1 while match holds).
//  irq <= PEND & IE (one cycle after PEND). IE=0 masks only, PEND still sets.
//  EN=0: count and prescaler frozen/cleared as above, no new PEND set.
//  CMP commit: new value used for match from next cycle; no auto-clear of PEND.
//  No back-pressure: every sel access completes in one cycle.
//  Async reset mid-access: access dropped, all state to reset values.
// CONFIGURATION
//  TIMER_CMP_PERIODIC_EN defined: PER_LO/PER_HI writable (same shadow scheme,
//   own shadow), CTRL.b3 writable; on match with PERIODIC=1, cmp<=cmp+per
//   (64-bit wrap) in the cycle PEND is set, so each period fires once.
//   per=0 with PERIODIC=1: cmp unchanged (level behaviour).
//  Not defined: PER_LO/PER_HI read 0, writes ignored; CTRL.b3 reads 0;
//   no adder instantiated; cmp changes only by bus writes.
// TESTING
//  1 Reset, read all 8 regs -> CNT=0, CMP=FFFFFFFF_FFFFFFFF, CTRL=0, irq=0.
//  2 PRESCALE=4, CTRL=1, wait 40 clk -> CNT_LO=10 (+/-1 per sample edge),
//    CNT_HI=0; CTRL=0 then wait 20 clk -> value unchanged.
//  3 CNT_LO=FFFFFFFE, CNT_HI=0, EN -> after 2 ticks read LO=0,HI=1 atomically;
//    mid-carry LO/HI read pair never returns {0,0} or {1,FFFFFFFE}.
//  4 CMP=0_00000020, CTRL=3 -> irq rises 2 clk after cnt reaches 0x20;
//    W1C PEND while cnt>=cmp -> PEND stays 1; write CMP=FFFF.. then W1C -> irq=0.
//  5 IE=0 with match -> irq=0, CTRL read shows PEND=1; set IE -> irq=1 next clk.
//  6 TIMER_CMP_PERIODIC_EN: CMP=10, PER=10, CTRL=0xB -> PEND sets at cnt 10,20,30;
//    clear between -> exactly 3 irq pulses by cnt 35. Undefined: PER reads 0.

Source files
------------

// File: rtl/timer_compare.sv
// Memory-mapped 64-bit machine timer: prescaled tick counter, compare register and level irq.
// Define TIMER_CMP_PERIODIC_EN to add the PER register and auto-reload of cmp on match.
module timer_compare #(
    parameter int PRESCALE = 100,
    parameter int PS_W     = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [63:0]     cnt_reg;
    logic [63:0]     cmp_reg;
    logic [31:0]     cnt_shadow_reg;
    logic [31:0]     cmp_shadow_reg;
    logic [31:0]     hi_latch_reg;
    logic [PS_W-1:0] ps_reg;
    logic            en_reg;
    logic            ie_reg;
    logic            pend_reg;
    logic            irq_reg;
    logic [31:0]     dout_reg;
    logic            periodic_bit;
    logic [63:0]     per_val;

    logic [2:0]  reg_idx;
    logic        rd_acc;
    logic [7:0]  wsel;
    logic        match;
    logic [31:0] rd_data;

    assign reg_idx = addr[4:2];
    assign rd_acc  = sel & ~we;
    assign match   = en_reg & (cnt_reg >= cmp_reg);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wsel
            assign wsel[gi] = sel & we & (reg_idx == 3'(gi));
        end
    endgenerate

    // Count register: a committed bus write wins over a same-cycle tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            cnt_shadow_reg <= '0;
            ps_reg         <= '0;
        end else begin
            if (wsel[0])
                cnt_shadow_reg <= din;
            if (wsel[1]) begin
                cnt_reg <= {din, cnt_shadow_reg};
                ps_reg  <= '0;
            end else if (!en_reg) begin
                ps_reg <= '0;
            end else if (ps_reg == PS_MAX) begin
                ps_reg  <= '0;
                cnt_reg <= cnt_reg + 64'd1;
            end else begin
                ps_reg <= ps_reg + 1'b1;
            end
        end
    end

`ifdef TIMER_CMP_PERIODIC_EN
    logic [63:0] per_reg;
    logic [31:0] per_shadow_reg;
    logic        periodic_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            per_reg        <= '0;
            per_shadow_reg <= '0;
            periodic_reg   <= 1'b0;
        end else begin
            if (wsel[5])
                per_shadow_reg <= din;
            if (wsel[6])
                per_reg <= {din, per_shadow_reg};
            if (wsel[4])
                periodic_reg <= din[3];
        end
    end

    assign periodic_bit = periodic_reg;
    assign per_val      = per_reg;

    // Advancing cmp together with PEND makes each period fire exactly once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmp_reg        <= '1;
            cmp_shadow_reg <= '0;
        end else begin
            if (wsel[2])
                cmp_shadow_reg <= din;
            if (wsel[3])
                cmp_reg <= {din, cmp_shadow_reg};
            else if (match && periodic_reg)
                cmp_reg <= cmp_reg + per_reg;
        end
    end
`else
    assign periodic_bit = 1'b0;
    assign per_val      = '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmp_reg        <= '1;
            cmp_shadow_reg <= '0;
        end else begin
            if (wsel[2])
                cmp_shadow_reg <= din;
            if (wsel[3])
                cmp_reg <= {din, cmp_shadow_reg};
        end
    end
`endif

    // PEND: a live match always beats a same-cycle write-one-to-clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_reg   <= 1'b0;
            ie_reg   <= 1'b0;
            pend_reg <= 1'b0;
            irq_reg  <= 1'b0;
        end else begin
            if (wsel[4]) begin
                en_reg <= din[0];
                ie_reg <= din[1];
            end
            if (match)
                pend_reg <= 1'b1;
            else if (wsel[4] && din[2])
                pend_reg <= 1'b0;
            irq_reg <= pend_reg & ie_reg;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            3'd0:    rd_data = cnt_reg[31:0];
            3'd1:    rd_data = hi_latch_reg;
            3'd2:    rd_data = cmp_reg[31:0];
            3'd3:    rd_data = hi_latch_reg;
            3'd4:    rd_data = {28'd0, periodic_bit, pend_reg, ie_reg, en_reg};
            3'd5:    rd_data = per_val[31:0];
            3'd6:    rd_data = per_val[63:32];
            default: rd_data = '0;
        endcase
    end

    // LO reads snapshot the upper word so the following HI read cannot tear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_reg     <= '0;
            hi_latch_reg <= '0;
        end else if (rd_acc) begin
            dout_reg <= rd_data;
            if (reg_idx == 3'd0)
                hi_latch_reg <= cnt_reg[63:32];
            else if (reg_idx == 3'd2)
                hi_latch_reg <= cmp_reg[63:32];
        end
    end

    assign dout = dout_reg;
    assign irq  = irq_reg;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[31:5], addr[1:0]};

endmodule

// File: tb/tb_timer_compare.sv
// Scoreboarded bench for timer_compare: reads push expected data, a monitor checks dout.
module tb_timer_compare;

    localparam logic [2:0] CNT_LO = 3'd0, CNT_HI = 3'd1, CMP_LO = 3'd2, CMP_HI = 3'd3,
                           CTRL = 3'd4, PER_LO = 3'd5, PER_HI = 3'd6, RSVD = 3'd7;

    logic        clock;
    logic        reset;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    timer_compare #(.PRESCALE(4), .PS_W(2)) dut (
        .clock(clock),
        .reset(reset),
        .sel  (sel),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Read data is valid one clock after the access edge.
    always @(posedge clock) begin
        if (sel && !we && !reset) begin
            #1;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_read", dout, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, dout, e.exp);
            end
        end
    end

    // Accesses start on a falling edge and occupy exactly one rising edge.
    task automatic wr(input logic [2:0] idx, input logic [31:0] data);
        sel  = 1'b1;
        we   = 1'b1;
        addr = {27'd0, idx, 2'b00};
        din  = data;
        @(negedge clock);
        sel = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        sel  = 1'b1;
        we   = 1'b0;
        addr = {27'd0, idx, 2'b00};
        @(negedge clock);
        sel = 1'b0;
    endtask

    initial begin
        int pulses;
        int cyc;
        logic prev_irq;

        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        repeat (3) @(negedge clock);
        check("reset_dout", dout, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Reset values of every register
        rd(CNT_LO, 32'd0,         "t1_cnt_lo");
        rd(CNT_HI, 32'd0,         "t1_cnt_hi");
        rd(CMP_LO, 32'hFFFF_FFFF, "t1_cmp_lo");
        rd(CMP_HI, 32'hFFFF_FFFF, "t1_cmp_hi");
        rd(CTRL,   32'd0,         "t1_ctrl");
        rd(PER_LO, 32'd0,         "t1_per_lo");
        rd(PER_HI, 32'd0,         "t1_per_hi");
        rd(RSVD,   32'd0,         "t1_rsvd");

        // Counting with PRESCALE=4: 40 clocks give 10 ticks, then freeze
        wr(CTRL, 32'd1);
        repeat (40) @(negedge clock);
        rd(CNT_LO, 32'd10, "t2_cnt_lo_run");
        rd(CNT_HI, 32'd0,  "t2_cnt_hi_run");
        wr(CTRL, 32'd0);
        repeat (20) @(negedge clock);
        rd(CNT_LO, 32'd10, "t2_cnt_lo_frozen");

        // Carry across the 32-bit boundary, tear-free pair reads
        wr(CNT_LO, 32'hFFFF_FFFE);
        wr(CNT_HI, 32'd0);
        rd(CNT_LO, 32'hFFFF_FFFE, "t3_load_lo");
        rd(CNT_HI, 32'd0,         "t3_load_hi");
        wr(CTRL, 32'd1);
        repeat (7) @(negedge clock);
        rd(CNT_LO, 32'hFFFF_FFFF, "t3_pre_carry_lo");
        rd(CNT_HI, 32'd0,         "t3_pre_carry_hi_latched");
        rd(CNT_LO, 32'd0,         "t3_post_carry_lo");
        rd(CNT_HI, 32'd1,         "t3_post_carry_hi");
        wr(CTRL, 32'd0);

        // Compare match: irq two clocks after cnt reaches 0x20
        wr(CNT_LO, 32'h1C);
        wr(CNT_HI, 32'd0);
        wr(CMP_LO, 32'h20);
        wr(CMP_HI, 32'd0);
        wr(CTRL, 32'd3);
        repeat (17) @(negedge clock);
        check("t4_irq_low_pend_cycle", {31'd0, irq}, 32'd0);
        @(negedge clock);
        check("t4_irq_rise", {31'd0, irq}, 32'd1);
        rd(CTRL, 32'd7, "t4_ctrl_pend");
        wr(CTRL, 32'd7);
        rd(CTRL, 32'd7, "t4_w1c_while_match");
        wr(CMP_LO, 32'hFFFF_FFFF);
        wr(CMP_HI, 32'hFFFF_FFFF);
        wr(CTRL, 32'd7);
        rd(CTRL, 32'd3, "t4_w1c_cleared");
        wr(CNT_LO, 32'd0);
        check("t4_dout_held_on_write", dout, 32'd3);
        check("t4_irq_after_clear", {31'd0, irq}, 32'd0);

        // Masked interrupt: PEND sets, irq follows only once IE is set
        wr(CTRL, 32'd1);
        wr(CMP_LO, 32'd0);
        wr(CMP_HI, 32'd0);
        repeat (3) @(negedge clock);
        check("t5_irq_masked", {31'd0, irq}, 32'd0);
        rd(CTRL, 32'd5, "t5_ctrl_pend_masked");
        wr(CTRL, 32'd3);
        check("t5_irq_same_clk", {31'd0, irq}, 32'd0);
        @(negedge clock);
        check("t5_irq_unmasked", {31'd0, irq}, 32'd1);
        wr(CTRL, 32'd4);
        rd(CTRL, 32'd4, "t5_set_beats_clear");
        wr(CTRL, 32'd4);
        rd(CTRL, 32'd0, "t5_clear_when_disabled");
        check("t5_irq_final", {31'd0, irq}, 32'd0);

`ifdef TIMER_CMP_PERIODIC_EN
        // Periodic reload: fires at cnt 10, 20, 30
        wr(CNT_LO, 32'd0);
        wr(CNT_HI, 32'd0);
        wr(CMP_LO, 32'd10);
        wr(CMP_HI, 32'd0);
        wr(PER_LO, 32'd10);
        wr(PER_HI, 32'd0);
        wr(CTRL, 32'hB);
        pulses   = 0;
        cyc      = 0;
        prev_irq = 1'b0;
        while (cyc < 140) begin
            if (irq && !prev_irq) begin
                pulses++;
                prev_irq = 1'b1;
                wr(CTRL, 32'hB);
            end else begin
                prev_irq = irq;
                @(negedge clock);
            end
            cyc++;
        end
        check("t6_pulse_count", 32'(pulses), 32'd3);
        wr(CTRL, 32'd4);
        rd(CMP_LO, 32'd40, "t6_cmp_advanced");
        rd(PER_LO, 32'd10, "t6_per_lo");
        rd(CTRL,   32'd0,  "t6_ctrl_off");
`else
        // Without the periodic option PER and CTRL.b3 are inert
        wr(PER_LO, 32'd5);
        wr(PER_HI, 32'd6);
        wr(CTRL, 32'h8);
        rd(PER_LO, 32'd0, "t6_per_lo_zero");
        rd(PER_HI, 32'd0, "t6_per_hi_zero");
        rd(CTRL,   32'd0, "t6_ctrl_b3_zero");
        pulses   = 0;
        cyc      = 0;
        prev_irq = 1'b0;
`endif

        // Asynchronous reset in the middle of a read access
        wr(CMP_LO, 32'h55);
        wr(CMP_HI, 32'h66);
        rd(CMP_LO, 32'h55, "t7_pre_reset_read");
        sel  = 1'b1;
        we   = 1'b0;
        addr = {27'd0, CTRL, 2'b00};
        #2;
        reset = 1'b1;
        #1;
        check("t7_async_dout", dout, 32'd0);
        check("t7_async_irq", {31'd0, irq}, 32'd0);
        @(negedge clock);
        sel   = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        rd(CMP_LO, 32'hFFFF_FFFF, "t7_cmp_lo_reset");
        rd(CMP_HI, 32'hFFFF_FFFF, "t7_cmp_hi_reset");
        rd(CTRL,   32'd0,         "t7_ctrl_reset");
        rd(CNT_LO, 32'd0,         "t7_cnt_lo_reset");

        repeat (3) @(negedge clock);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
